// File: rtl/program_loader.sv
// Byte-stream program loader: a header byte gives the word count N, then N big-endian
// 16-bit words fill program memory while the CPU is held until the load completes.
module program_loader #(
  parameter int nBit  = 16,
  parameter int DEPTH = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  input  logic            reload,
  input  logic [5:0]      PC,
  output logic [nBit-1:0] data_from_rom,
  output logic            cpu_hold,
  output logic            done,
  output logic            err,
  output logic [6:0]      word_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_HI = 3'd1,
    S_LOAD_LO = 3'd2,
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [6:0]      r_n;
  logic [7:0]      r_hi;
  logic [5:0]      r_waddr;
  logic [6:0]      r_word_count;
  logic [nBit-1:0] r_mem [DEPTH];

  logic w_xfer;
  logic w_header_ok;
  logic w_last_word;

  assign w_xfer      = rx_valid && rx_ready;
  assign w_header_ok = (rx_data[7] == 1'b0) && (rx_data[6:0] != 7'd0) && (rx_data[6:0] <= 7'd64);
  assign w_last_word = ((r_word_count + 7'd1) == r_n);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_next_state = w_header_ok ? S_LOAD_HI : S_ERROR;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_LOAD_HI: begin
        if (w_xfer) begin
          w_next_state = S_LOAD_LO;
        end else begin
          w_next_state = S_LOAD_HI;
        end
      end
      S_LOAD_LO: begin
        if (w_xfer) begin
          w_next_state = w_last_word ? S_DONE : S_LOAD_HI;
        end else begin
          w_next_state = S_LOAD_LO;
        end
      end
      S_DONE, S_ERROR: begin
        if (reload) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = r_state;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b1;
    cpu_hold = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD_HI, S_LOAD_LO: begin
        rx_ready = 1'b1;
      end
      S_DONE: begin
        rx_ready = 1'b0;
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      S_ERROR: begin
        rx_ready = 1'b0;
        err      = 1'b1;
      end
      default: begin
        rx_ready = 1'b1;
      end
    endcase
  end

  // Header latch, held high byte, write address and word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n          <= 7'd0;
      r_hi         <= 8'd0;
      r_waddr      <= 6'd0;
      r_word_count <= 7'd0;
    end else if (w_xfer) begin
      case (r_state)
        S_IDLE: begin
          if (w_header_ok) begin
            r_n          <= rx_data[6:0];
            r_waddr      <= 6'd0;
            r_word_count <= 7'd0;
          end
        end
        S_LOAD_HI: r_hi <= rx_data;
        S_LOAD_LO: begin
          r_word_count <= r_word_count + 7'd1;
          // Hold the address on the final word so it never passes N-1.
          if (!w_last_word) begin
            r_waddr <= r_waddr + 6'd1;
          end
        end
        default: r_hi <= r_hi;
      endcase
    end
  end

  // Program memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (!reset && w_xfer && (r_state == S_LOAD_LO)) begin
      r_mem[r_waddr] <= {r_hi, rx_data};
    end
  end

  assign word_count    = r_word_count;
  assign data_from_rom = cpu_hold ? {nBit{1'b0}} : r_mem[PC];

endmodule

// File: tb/tb_program_loader.sv
// Randomized and directed bench for program_loader, checked against a byte-count model.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic [5:0]  PC;
  logic [15:0] data_from_rom;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [6:0]  word_count;

  int checks   = 0;
  int failures = 0;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  int          m_mode;
  int          m_k;
  int          m_n;
  int          m_wc;
  logic [7:0]  m_hi;
  logic [15:0] m_mem [64];
  bit          m_wr  [64];

  program_loader #(.nBit(16), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .reload(reload), .PC(PC), .data_from_rom(data_from_rom), .cpu_hold(cpu_hold),
    .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs();
    check("rx_ready", 32'(rx_ready), 32'(m_mode == M_IDLE || m_mode == M_LOAD));
    check("cpu_hold", 32'(cpu_hold), 32'(m_mode != M_DONE));
    check("done", 32'(done), 32'(m_mode == M_DONE));
    check("err", 32'(err), 32'(m_mode == M_ERR));
    check("word_count", 32'(word_count), 32'(m_wc));
    if (m_mode != M_DONE) begin
      check("rom_held", 32'(data_from_rom), 32'h0);
    end else if (m_wr[PC]) begin
      check("rom_data", 32'(data_from_rom), 32'(m_mem[PC]));
    end
  endtask

  task automatic model_update(input bit v, input logic [7:0] d, input bit rl, input bit rs);
    bit xfer;
    xfer = v && (m_mode == M_IDLE || m_mode == M_LOAD);
    if (rs) begin
      m_mode = M_IDLE;
      m_wc   = 0;
      m_k    = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (xfer) begin
          m_n = int'(d[6:0]);
          if (d[7] || m_n == 0 || m_n > 64) m_mode = M_ERR;
          else begin
            m_mode = M_LOAD;
            m_k    = 0;
            m_wc   = 0;
          end
        end
        M_LOAD: if (xfer) begin
          if (m_k % 2 == 0) m_hi = d;
          else begin
            m_mem[m_k / 2] = {m_hi, d};
            m_wr[m_k / 2]  = 1'b1;
            m_wc = m_k / 2 + 1;
            if (m_wc == m_n) m_mode = M_DONE;
          end
          m_k++;
        end
        default: if (rl) m_mode = M_IDLE;
      endcase
    end
  endtask

  // One clock: drive at the falling edge, compare, clock, advance the model.
  task automatic step(input bit v, input logic [7:0] d, input bit rl, input bit rs, input logic [5:0] pc);
    rx_valid = v;
    rx_data  = d;
    reload   = rl;
    reset    = rs;
    PC       = pc;
    #1;
    compare_outputs();
    @(posedge clk);
    model_update(v, d, rl, rs);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic peek(input logic [5:0] pc);
    rx_valid = 1'b0;
    reload   = 1'b0;
    reset    = 1'b0;
    PC       = pc;
    #1;
  endtask

  initial begin
    logic [7:0] d;
    bit v;
    m_mode = M_IDLE; m_k = 0; m_n = 0; m_wc = 0; m_hi = 8'h00;
    for (int i = 0; i < 64; i++) m_wr[i] = 1'b0;
    @(negedge clk);
    step(1'b0, 8'h00, 1'b0, 1'b1, 6'd0);
    step(1'b1, 8'h05, 1'b1, 1'b1, 6'd0);
    peek(6'd0);
    check("rst_ready", 32'(rx_ready), 32'h1);
    check("rst_hold", 32'(cpu_hold), 32'h1);
    check("rst_wc", 32'(word_count), 32'h0);

    // Two-word load, valid held high.
    send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    peek(6'd1);
    check("l2_done", 32'(done), 32'h1);
    check("l2_wc", 32'(word_count), 32'h2);
    check("l2_pc1", 32'(data_from_rom), 32'hABCD);
    peek(6'd0);
    check("l2_pc0", 32'(data_from_rom), 32'h1234);
    step(1'b0, 8'h00, 1'b1, 1'b0, 6'd0);
    peek(6'd1);
    check("reload_done", 32'(done), 32'h0);
    check("reload_hold", 32'(cpu_hold), 32'h1);
    check("reload_rom", 32'(data_from_rom), 32'h0);

    // Same load with valid toggling; reload in the middle is ignored.
    foreach (m_hi[i]) ;
    begin
      logic [7:0] bytes [5];
      bytes[0] = 8'h02; bytes[1] = 8'h12; bytes[2] = 8'h34; bytes[3] = 8'hAB; bytes[4] = 8'hCD;
      for (int i = 0; i < 5; i++) begin
        step(1'b1, bytes[i], 1'b0, 1'b0, 6'd0);
        step(1'b0, 8'hEE, (i == 2), 1'b0, 6'd0);
      end
    end
    peek(6'd1);
    check("tog_done", 32'(done), 32'h1);
    check("tog_pc1", 32'(data_from_rom), 32'hABCD);
    step(1'b0, 8'h00, 1'b1, 1'b0, 6'd0);

    // Bad headers.
    send(8'h00);
    peek(6'd0);
    check("h00_err", 32'(err), 32'h1);
    check("h00_ready", 32'(rx_ready), 32'h0);
    check("h00_hold", 32'(cpu_hold), 32'h1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 6'd0);
    peek(6'd0);
    check("h00_clear", 32'(err), 32'h0);
    send(8'h41);
    peek(6'd0);
    check("h41_err", 32'(err), 32'h1);
    check("h41_ready", 32'(rx_ready), 32'h0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 6'd0);
    send(8'h81);
    peek(6'd0);
    check("h81_err", 32'(err), 32'h1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 6'd0);

    // Full 64-word load; extra bytes are refused.
    send(8'h40);
    for (int i = 0; i < 128; i++) send(8'(i));
    send(8'h55); send(8'h66);
    peek(6'd63);
    check("full_pc63", 32'(data_from_rom), 32'h7E7F);
    check("full_wc", 32'(word_count), 32'd64);
    check("full_done", 32'(done), 32'h1);
    check("full_ready", 32'(rx_ready), 32'h0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 6'd0);

    // Reset mid-word drops the byte and keeps memory.
    send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    step(1'b1, 8'h44, 1'b0, 1'b1, 6'd0);
    peek(6'd0);
    check("mid_rst_wc", 32'(word_count), 32'h0);
    check("mid_rst_hold", 32'(cpu_hold), 32'h1);
    check("mid_rst_ready", 32'(rx_ready), 32'h1);
    send(8'h01); send(8'hAA); send(8'hBB);
    peek(6'd1);
    check("retain_pc1", 32'(data_from_rom), 32'h0203);
    peek(6'd0);
    check("new_pc0", 32'(data_from_rom), 32'hAABB);
    step(1'b0, 8'h00, 1'b1, 1'b0, 6'd0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      if (m_mode == M_IDLE && $urandom_range(0, 9) < 8) d = 8'($urandom_range(1, 12));
      step(v, d, ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0), 6'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
